// File: rtl/sdr_16_rd_capture_pkg.sv
// Shared SDR SDRAM definitions: command and burst encodings,
// CAS latency limits and the read-capture FSM state type.
package sdr_pkg;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_RFR = 3'b001,
    CMD_PCH = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_NOP = 3'b111
  } sdr_cmd_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'd0,
    BTE_BEAT4  = 2'd1,
    BTE_BEAT8  = 2'd2,
    BTE_BEAT16 = 2'd3
  } sdr_bte_e;

  localparam int SDR_CL_2 = 2;
  localparam int SDR_CL_3 = 3;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_LO   = 1'b1
  } cap_state_e;

endpackage

// File: rtl/sdr_16_rd_capture_if.sv
// Read-return bundle between the SDRAM command side and capture.
// rd_ovf/ovf_cnt exist only when SDR_RD_OVF_DET_EN is defined.
interface sdr_16_rd_capture_if #(
  parameter int DW = 16
);

  logic            cmd_read;
  logic [DW-1:0]   dq_i;
  logic            fifo_full;
  logic [2*DW-1:0] rd_data;
  logic            rd_we;
  logic            rd_busy;
  logic            proto_err;
`ifdef SDR_RD_OVF_DET_EN
  logic            rd_ovf;
  logic [7:0]      ovf_cnt;
`endif

  modport master (
    output cmd_read,
    output dq_i,
    output fifo_full,
`ifdef SDR_RD_OVF_DET_EN
    input  rd_ovf,
    input  ovf_cnt,
`endif
    input  rd_data,
    input  rd_we,
    input  rd_busy,
    input  proto_err
  );

  modport slave (
    input  cmd_read,
    input  dq_i,
    input  fifo_full,
`ifdef SDR_RD_OVF_DET_EN
    output rd_ovf,
    output ovf_cnt,
`endif
    output rd_data,
    output rd_we,
    output rd_busy,
    output proto_err
  );

endinterface

// File: rtl/sdr_16_rd_capture_dly.sv
// Single-bit delay line of depth D; the whole pipe is exposed
// so the parent can tell when nothing is in flight.
module sdr_rd_dly #(
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         d,
  output logic [D-1:0] pipe
);

  // Shift in every cycle, never stalls; bit D-1 is the tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= D'({pipe, d});
  end

endmodule

// File: rtl/sdr_16_rd_capture.sv
// SDR SDRAM read return: delays cmd_read by CL+IN_REG, captures
// two DQ halves and writes one 32-bit word. Option: SDR_RD_OVF_DET_EN.
module sdr_16_rd_capture
  import sdr_pkg::*;
#(
  parameter int CL     = 2,
  parameter int IN_REG = 1,
  parameter int DW     = 16
) (
  input logic               sdram_clk,
  input logic               sdram_rst_n,
  sdr_16_rd_capture_if.slave bus
);

  localparam int D = CL + IN_REG;

  logic [D-1:0]    pipe;
  logic            tap;
  logic [DW-1:0]   dq_s;
  logic [DW-1:0]   hi_reg;
  cap_state_e      state;
  logic [2*DW-1:0] data_q;
  logic            we_q;
  logic            perr_q;

  sdr_rd_dly #(.D(D)) u_dly (
    .clk   (sdram_clk),
    .rst_n (sdram_rst_n),
    .d     (bus.cmd_read),
    .pipe  (pipe)
  );

  assign tap = pipe[D-1];

  if (IN_REG != 0) begin : g_in_reg
    logic [DW-1:0] dq_q;
    // Pad register on DQ, sampled every cycle.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
      if (!sdram_rst_n) dq_q <= '0;
      else              dq_q <= bus.dq_i;
    end
    assign dq_s = dq_q;
  end else begin : g_no_reg
    assign dq_s = bus.dq_i;
  end

  // Capture FSM: high half on tap, low half next cycle.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state  <= CAP_IDLE;
      hi_reg <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state)
        CAP_IDLE: begin
          if (tap) begin
            hi_reg <= dq_s;
            state  <= CAP_LO;
          end
        end
        CAP_LO: begin
          data_q <= {hi_reg, dq_s};
          we_q   <= 1'b1;
          if (tap) perr_q <= 1'b1;
          state  <= CAP_IDLE;
        end
        default: state <= CAP_IDLE;
      endcase
    end
  end

  assign bus.rd_data   = data_q;
  assign bus.rd_we     = we_q;
  assign bus.proto_err = perr_q;
  assign bus.rd_busy   = (|pipe) | (state == CAP_LO) | we_q;

`ifdef SDR_RD_OVF_DET_EN
  logic       ovf_q;
  logic [7:0] cnt_q;

  // Writes into a full FIFO: sticky flag plus saturating count.
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (we_q && bus.fifo_full) begin
      ovf_q <= 1'b1;
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.rd_ovf  = ovf_q;
  assign bus.ovf_cnt = cnt_q;
`else
  logic unused_fifo_full;
  assign unused_fifo_full = bus.fifo_full;
`endif

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Scoreboard bench: dut_a CL=2/IN_REG=1, dut_b CL=3/IN_REG=0.
// Overflow checks are compiled in with SDR_RD_OVF_DET_EN.
module tb_sdr_16_rd_capture;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   t = 0;
  int   test = 0;
  logic act = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] w4 [4] = '{32'h00010002, 32'h00030004,
                          32'h00050006, 32'h00070008};

  sdr_16_rd_capture_if #(.DW(16)) bus_a ();
  sdr_16_rd_capture_if #(.DW(16)) bus_b ();

  sdr_16_rd_capture #(.CL(2), .IN_REG(1), .DW(16)) dut_a (
    .sdram_clk   (clk),
    .sdram_rst_n (rst_n),
    .bus         (bus_a.slave)
  );

  sdr_16_rd_capture #(.CL(3), .IN_REG(0), .DW(16)) dut_b (
    .sdram_clk   (clk),
    .sdram_rst_n (rst_n),
    .bus         (bus_b.slave)
  );

  always #5 clk = ~clk;

  function automatic logic busy_a(int id, int k);
    case (id)
      1:       return k >= 11 && k <= 15;
      2:       return k >= 11 && k <= 21;
      4:       return k >= 11 && k <= 15;
      5:       return k == 11;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic perr_a(int id, int k);
    case (id)
      4:       return k >= 15;
      5:       return k < 12;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic busy_b(int id, int k);
    return id == 3 && k >= 11 && k <= 15;
  endfunction

  // Monitor: pops expected words on rd_we, checks levels each cycle.
  always @(negedge clk) begin
    if (act) begin
      if (bus_a.rd_we) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_we_unexp test=%0d t=%0d got %h want none",
                   test, t, bus_a.rd_data);
        end else begin
          exp_t e;
          e = qa.pop_front();
          if (e.cyc != t || e.data != bus_a.rd_data) begin
            errors++;
            $display("FAIL a_word test=%0d got t=%0d %h want t=%0d %h",
                     test, t, bus_a.rd_data, e.cyc, e.data);
          end
        end
      end
      if (bus_b.rd_we) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_we_unexp test=%0d t=%0d got %h want none",
                   test, t, bus_b.rd_data);
        end else begin
          exp_t e;
          e = qb.pop_front();
          if (e.cyc != t || e.data != bus_b.rd_data) begin
            errors++;
            $display("FAIL b_word test=%0d got t=%0d %h want t=%0d %h",
                     test, t, bus_b.rd_data, e.cyc, e.data);
          end
        end
      end
      checks++;
      if (bus_a.rd_busy !== busy_a(test, t)) begin
        errors++;
        $display("FAIL a_busy test=%0d t=%0d got %b want %b",
                 test, t, bus_a.rd_busy, busy_a(test, t));
      end
      checks++;
      if (bus_a.proto_err !== perr_a(test, t)) begin
        errors++;
        $display("FAIL a_perr test=%0d t=%0d got %b want %b",
                 test, t, bus_a.proto_err, perr_a(test, t));
      end
      checks++;
      if (bus_b.rd_busy !== busy_b(test, t)) begin
        errors++;
        $display("FAIL b_busy test=%0d t=%0d got %b want %b",
                 test, t, bus_b.rd_busy, busy_b(test, t));
      end
      checks++;
      if (bus_b.proto_err !== 1'b0) begin
        errors++;
        $display("FAIL b_perr test=%0d t=%0d got %b want 0",
                 test, t, bus_b.proto_err);
      end
      if (test == 5 && (t == 11 || t == 12)) begin
        logic [31:0] want;
        want = (t == 11) ? 32'hC0DEBEEF : 32'h0;
        checks++;
        if (bus_a.rd_data !== want || bus_a.rd_we !== 1'b0) begin
          errors++;
          $display("FAIL a_hold_rst t=%0d got %h/%b want %h/0",
                   t, bus_a.rd_data, bus_a.rd_we, want);
        end
      end
`ifdef SDR_RD_OVF_DET_EN
      if (test == 2 && (t == 0 || t == 16 || t == 25)) begin
        logic       wo;
        logic [7:0] wc;
        wo = (t != 0);
        wc = (t == 0) ? 8'd0 : (t == 16) ? 8'd1 : 8'd2;
        checks++;
        if (bus_a.rd_ovf !== wo || bus_a.ovf_cnt !== wc) begin
          errors++;
          $display("FAIL a_ovf t=%0d got %b/%0d want %b/%0d",
                   t, bus_a.rd_ovf, bus_a.ovf_cnt, wo, wc);
        end
      end
`endif
      if (t == 25) begin
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
          errors++;
          $display("FAIL missing_we test=%0d got left a=%0d b=%0d want 0",
                   test, qa.size(), qb.size());
          qa.delete();
          qb.delete();
        end
      end
    end
  end

  task automatic drive(input int id, input int k);
    bus_a.cmd_read  = 1'b0;
    bus_b.cmd_read  = 1'b0;
    bus_a.fifo_full = 1'b0;
    bus_b.fifo_full = 1'b0;
    bus_a.dq_i = 16'hE000 | 16'(k);
    bus_b.dq_i = 16'hD000 | 16'(k);
    case (id)
      1: begin
        if (k == 10) begin
          bus_a.cmd_read = 1'b1;
          qa.push_back('{15, 32'hA5A55A5A});
        end
        if (k == 12) bus_a.dq_i = 16'hA5A5;
        if (k == 13) bus_a.dq_i = 16'h5A5A;
      end
      2: begin
        if (k >= 10 && k <= 16 && k % 2 == 0) begin
          bus_a.cmd_read = 1'b1;
          qa.push_back('{k + 5, w4[(k - 10) / 2]});
        end
        if (k >= 12 && k <= 19) bus_a.dq_i = 16'(k - 11);
        if (k == 15 || k == 17) bus_a.fifo_full = 1'b1;
      end
      3: begin
        if (k == 10) begin
          bus_b.cmd_read = 1'b1;
          qb.push_back('{15, 32'h12345678});
        end
        if (k == 13) bus_b.dq_i = 16'h1234;
        if (k == 14) bus_b.dq_i = 16'h5678;
      end
      4: begin
        if (k == 10 || k == 11) bus_a.cmd_read = 1'b1;
        if (k == 10) qa.push_back('{15, 32'hC0DEBEEF});
        if (k == 12) bus_a.dq_i = 16'hC0DE;
        if (k == 13) bus_a.dq_i = 16'hBEEF;
      end
      5: begin
        if (k == 10) bus_a.cmd_read = 1'b1;
        if (k == 12) rst_n = 1'b0;
        if (k == 13) rst_n = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic run_test(input int id);
    if (id != 5) begin
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    end
    test = id;
    for (int k = 0; k < 26; k++) begin
      @(posedge clk);
      #1;
      t = k;
      drive(id, k);
      act = 1'b1;
    end
    @(posedge clk);
    #1;
    act = 1'b0;
  endtask

  initial begin
    drive(0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_test(1);
    run_test(2);
    run_test(3);
    run_test(4);
    run_test(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
